// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor.
// Each stage resolves one SEG-bit segment with 4-bit lookahead groups and
// registers the segment carry for the next stage. Operand segments are skewed
// on the way in and result segments de-skewed on the way out so that every
// full-width result leaves the last stage aligned. A single global enable
// stalls the whole pipe when the output is held by backpressure.
module cla_pipe_adder #(
  parameter int WIDTH = 64,
  parameter int SEG   = 16,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op_sub,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [TAG_W-1:0] tag_out
);

  localparam int NSTAGE = WIDTH / SEG;
  localparam int NGRP   = SEG / 4;

  logic              en;
  logic [WIDTH-1:0]  b_eff;
  logic              c0;
  logic [NSTAGE-1:0] valid_reg;
  logic [TAG_W-1:0]  tag_reg [NSTAGE];
  logic [NSTAGE-1:0] carry_w;
  logic              ovf_reg;

  // The pipe only stops when a finished result is waiting on the consumer.
  assign en       = !(out_valid && !out_ready);
  assign in_ready = en;

  // Subtraction is A + ~B + 1; a borrow-in removes the +1.
  assign b_eff = op_sub ? ~b : b;
  assign c0    = cin ^ op_sub;

  assign out_valid = valid_reg[NSTAGE-1];
  assign tag_out   = tag_reg[NSTAGE-1];
  assign cout      = carry_w[NSTAGE-1];
  assign ovf       = ovf_reg;

  // Valid bits and tags march down the pipe alongside the data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= '0;
      for (int k = 0; k < NSTAGE; k++) begin
        tag_reg[k] <= '0;
      end
    end else if (en) begin
      valid_reg[0] <= in_valid;
      tag_reg[0]   <= tag_in;
      for (int k = 1; k < NSTAGE; k++) begin
        valid_reg[k] <= valid_reg[k-1];
        tag_reg[k]   <= tag_reg[k-1];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NSTAGE; gi++) begin : g_stage
      logic [SEG-1:0]  a_seg;
      logic [SEG-1:0]  b_seg;
      logic            c_in;
      logic [SEG-1:0]  g_bit;
      logic [SEG-1:0]  p_bit;
      logic [SEG-1:0]  bit_c;
      logic [SEG-1:0]  s_seg;
      logic [NGRP-1:0] grp_g;
      logic [NGRP-1:0] grp_p;
      logic [NGRP:0]   grp_c;
      logic            carry_reg;
      logic [SEG-1:0]  res_sk [gi:NSTAGE-1];

      if (gi == 0) begin : g_head
        assign a_seg = a[SEG-1:0];
        assign b_seg = b_eff[SEG-1:0];
        assign c_in  = c0;
      end else begin : g_skew
        logic [SEG-1:0] a_sk [gi];
        logic [SEG-1:0] b_sk [gi];

        // Delay this operand segment until its carry arrives from stage gi-1.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            for (int j = 0; j < gi; j++) begin
              a_sk[j] <= '0;
              b_sk[j] <= '0;
            end
          end else if (en) begin
            a_sk[0] <= a[gi*SEG +: SEG];
            b_sk[0] <= b_eff[gi*SEG +: SEG];
            for (int j = 1; j < gi; j++) begin
              a_sk[j] <= a_sk[j-1];
              b_sk[j] <= b_sk[j-1];
            end
          end
        end

        assign a_seg = a_sk[gi-1];
        assign b_seg = b_sk[gi-1];
        assign c_in  = carry_w[gi-1];
      end

      // Two-level lookahead: group carries are flat sums of products of the
      // group G/P terms and the segment carry-in, never chained group to group.
      always_comb begin : p_cla
        logic run_p;
        logic acc;
        run_p = 1'b1;
        acc   = 1'b0;
        g_bit = a_seg & b_seg;
        p_bit = a_seg ^ b_seg;
        grp_g = '0;
        grp_p = '0;
        grp_c = '0;
        bit_c = '0;
        for (int g = 0; g < NGRP; g++) begin
          grp_p[g] = &p_bit[4*g +: 4];
          grp_g[g] = g_bit[4*g+3]
                   | (p_bit[4*g+3] & g_bit[4*g+2])
                   | (p_bit[4*g+3] & p_bit[4*g+2] & g_bit[4*g+1])
                   | (p_bit[4*g+3] & p_bit[4*g+2] & p_bit[4*g+1] & g_bit[4*g]);
        end
        for (int g = 0; g <= NGRP; g++) begin
          run_p = 1'b1;
          acc   = 1'b0;
          for (int j = g - 1; j >= 0; j--) begin
            acc   = acc | (grp_g[j] & run_p);
            run_p = run_p & grp_p[j];
          end
          grp_c[g] = acc | (c_in & run_p);
        end
        for (int g = 0; g < NGRP; g++) begin
          for (int i = 0; i < 4; i++) begin
            run_p = 1'b1;
            acc   = 1'b0;
            for (int j = i - 1; j >= 0; j--) begin
              acc   = acc | (g_bit[4*g+j] & run_p);
              run_p = run_p & p_bit[4*g+j];
            end
            bit_c[4*g+i] = acc | (grp_c[g] & run_p);
          end
        end
        s_seg = p_bit ^ bit_c;
      end

      // Register the segment carry and result, then hold the result back
      // until the upper segments catch up.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          carry_reg <= 1'b0;
          for (int j = gi; j < NSTAGE; j++) begin
            res_sk[j] <= '0;
          end
        end else if (en) begin
          carry_reg   <= grp_c[NGRP];
          res_sk[gi]  <= s_seg;
          for (int j = gi + 1; j < NSTAGE; j++) begin
            res_sk[j] <= res_sk[j-1];
          end
        end
      end

      assign carry_w[gi]          = carry_reg;
      assign sum[gi*SEG +: SEG]   = res_sk[NSTAGE-1];

      if (gi == NSTAGE - 1) begin : g_ovf
        // Signed overflow: like-signed operands producing an opposite-signed sum.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            ovf_reg <= 1'b0;
          end else if (en) begin
            ovf_reg <= (a_seg[SEG-1] == b_seg[SEG-1]) && (s_seg[SEG-1] != a_seg[SEG-1]);
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder: three instances (16/4, 64/16, 32/32) share one
// clock and reset. Instance 0 gets the directed vectors; all three get a
// random regression. A scoreboard built from plain signed/unsigned arithmetic
// checks every presented result.
module tb_cla_pipe_adder;

  localparam int NI = 3;

  function automatic int wof(input int i);
    return (i == 0) ? 16 : (i == 1) ? 64 : 32;
  endfunction

  function automatic int sof(input int i);
    return (i == 0) ? 4 : (i == 1) ? 16 : 32;
  endfunction

  logic clk = 1'b0;
  logic rst_n;
  logic [NI-1:0]       in_valid_d, out_ready_d, cin_d, sub_d;
  logic [NI-1:0][63:0] a_d, b_d;
  logic [NI-1:0][3:0]  tag_d;
  logic [NI-1:0]       in_ready_q, out_valid_q, cout_q, ovf_q;
  logic [NI-1:0][63:0] sum_q;
  logic [NI-1:0][3:0]  tag_q;

  int checks = 0;
  int passes = 0;
  logic [69:0] sb [NI][$];

  always #5 clk = ~clk;

  genvar gi;
  for (gi = 0; gi < NI; gi++) begin : g_dut
    localparam int W = wof(gi);
    localparam int S = sof(gi);
    logic [W-1:0] sum_l;
    cla_pipe_adder #(.WIDTH(W), .SEG(S), .TAG_W(4)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid_d[gi]),
      .in_ready (in_ready_q[gi]),
      .a        (a_d[gi][W-1:0]),
      .b        (b_d[gi][W-1:0]),
      .cin      (cin_d[gi]),
      .op_sub   (sub_d[gi]),
      .tag_in   (tag_d[gi]),
      .out_valid(out_valid_q[gi]),
      .out_ready(out_ready_d[gi]),
      .sum      (sum_l),
      .cout     (cout_q[gi]),
      .ovf      (ovf_q[gi]),
      .tag_out  (tag_q[gi])
    );
    assign sum_q[gi] = 64'(sum_l);
  end

  // Reference: returns {cout, ovf, sum} from whole-number arithmetic.
  function automatic logic [65:0] model(input logic [63:0] a, input logic [63:0] b,
                                        input logic cin, input logic sub, input int w);
    logic [66:0] m, ua, ub, ur, ea, eb;
    logic signed [66:0] sr, lim;
    logic co, ov;
    m  = (67'd1 << w) - 67'd1;
    ua = {3'b0, a} & m;
    ub = {3'b0, b} & m;
    ea = ua;
    eb = ub;
    if (ua[w-1]) ea = ua | ~m;
    if (ub[w-1]) eb = ub | ~m;
    lim = 67'sd1 <<< (w - 1);
    if (sub) begin
      ur = ua - ub - 67'(cin);
      co = (ua >= ub + 67'(cin));
      sr = $signed(ea) - $signed(eb) - $signed({66'd0, cin});
    end else begin
      ur = ua + ub + 67'(cin);
      co = (ur > m);
      sr = $signed(ea) + $signed(eb) + $signed({66'd0, cin});
    end
    ov = (sr >= lim) || (sr < -lim);
    return {co, ov, ur[63:0] & m[63:0]};
  endfunction

  task automatic check(input string nm, input int inst, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s inst%0d: got %h expected %h", nm, inst, act, exp);
  endtask

  // Per-cycle scoreboard, run between clock edges.
  task automatic monitor();
    logic [69:0] e;
    for (int i = 0; i < NI; i++) begin
      if (!rst_n) begin
        sb[i].delete();
        check("rst_out_valid", i, 64'(out_valid_q[i]), 64'd0);
      end else begin
        check("in_ready_rule", i, 64'(in_ready_q[i]), 64'(!(out_valid_q[i] && !out_ready_d[i])));
        if (out_valid_q[i]) begin
          check("result_expected", i, 64'(sb[i].size() != 0), 64'd1);
          if (sb[i].size() != 0) begin
            e = sb[i][0];
            check("sum", i, sum_q[i], e[63:0]);
            check("ovf", i, 64'(ovf_q[i]), 64'(e[64]));
            check("cout", i, 64'(cout_q[i]), 64'(e[65]));
            check("tag", i, 64'(tag_q[i]), 64'(e[69:66]));
            if (out_ready_d[i]) void'(sb[i].pop_front());
          end
        end
        if (in_valid_d[i] && in_ready_q[i])
          sb[i].push_back({tag_d[i], model(a_d[i], b_d[i], cin_d[i], sub_d[i], wof(i))});
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(input int i);
    int n;
    n = 0;
    #1;
    while (!in_ready_q[i] && n < 100) begin
      tick();
      n++;
    end
    check("accept_in_time", i, 64'(in_ready_q[i]), 64'd1);
    tick();
    in_valid_d[i] = 1'b0;
  endtask

  task automatic issue(input int i, input logic [63:0] a, input logic [63:0] b,
                       input logic cin, input logic sub, input logic [3:0] tag);
    a_d[i] = a; b_d[i] = b; cin_d[i] = cin; sub_d[i] = sub; tag_d[i] = tag;
    in_valid_d[i] = 1'b1;
    wait_accept(i);
  endtask

  // One op on instance 0 (4 stages): checks latency and literal results.
  task automatic run_lit(input logic [63:0] a, input logic [63:0] b, input logic cin, input logic sub,
                         input logic [63:0] es, input logic ec, input logic eo);
    issue(0, a, b, cin, sub, 4'hA);
    for (int k = 0; k < 3; k++) begin
      check("lat_not_yet", 0, 64'(out_valid_q[0]), 64'd0);
      tick();
    end
    check("lat_valid", 0, 64'(out_valid_q[0]), 64'd1);
    check("lit_sum", 0, sum_q[0], es);
    check("lit_cout", 0, 64'(cout_q[0]), 64'(ec));
    check("lit_ovf", 0, 64'(ovf_q[0]), 64'(eo));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb[0].size() != 0 || sb[1].size() != 0 || sb[2].size() != 0 || out_valid_q != '0) && n < 60) begin
      tick();
      n++;
    end
    for (int i = 0; i < NI; i++) check("drained", i, 64'(sb[i].size()), 64'd0);
  endtask

  function automatic logic [63:0] rnd64();
    case ($urandom_range(0, 7))
      0:       return '1;
      1:       return 64'h0;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin : main
    logic [65:0] r;
    int acc_cnt [NI];
    int target [NI];
    int cyc;
    rst_n = 1'b0;
    in_valid_d = '0; out_ready_d = '1; cin_d = '0; sub_d = '0;
    a_d = '0; b_d = '0; tag_d = '0;
    #2;
    for (int i = 0; i < NI; i++) begin
      check("reset_valid", i, 64'(out_valid_q[i]), 64'd0);
      check("reset_in_ready", i, 64'(in_ready_q[i]), 64'd1);
      check("reset_sum", i, sum_q[i], 64'd0);
    end
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check("post_reset_in_ready", 0, 64'(in_ready_q[0]), 64'd1);

    // Pin the reference model to hand-computed values.
    r = model(64'hFFFF, 64'h1, 1'b0, 1'b0, 16);
    check("pin_add_sum", 0, r[63:0], 64'h0);
    check("pin_add_cout", 0, 64'(r[65]), 64'd1);
    r = model(64'h7FFF, 64'h1, 1'b0, 1'b0, 16);
    check("pin_ovf", 0, 64'(r[64]), 64'd1);
    r = model(64'h5, 64'h7, 1'b1, 1'b1, 16);
    check("pin_sub_borrow", 0, r[63:0], 64'hFFFD);
    r = model(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64);
    check("pin_64_cout", 1, 64'(r[65]), 64'd1);
    r = model(64'h0, 64'h1, 1'b0, 1'b1, 32);
    check("pin_32_sub", 2, r[63:0], 64'hFFFF_FFFF);

    // Directed literal vectors on the 4-stage instance.
    run_lit(64'hFFFF, 64'h0001, 1'b0, 1'b0, 64'h0000, 1'b1, 1'b0);
    run_lit(64'h7FFF, 64'h0001, 1'b0, 1'b0, 64'h8000, 1'b0, 1'b1);
    run_lit(64'h0005, 64'h0007, 1'b0, 1'b1, 64'hFFFE, 1'b0, 1'b0);
    run_lit(64'h0005, 64'h0007, 1'b1, 1'b1, 64'hFFFD, 1'b0, 1'b0);
    run_lit(64'h8000, 64'h0001, 1'b0, 1'b1, 64'h7FFF, 1'b1, 1'b1);
    run_lit(64'h00FF, 64'h0F00, 1'b1, 1'b0, 64'h1000, 1'b0, 1'b0);

    // Back-to-back: 8 accepts, tags 0..7.
    for (int k = 0; k < 8; k++)
      issue(0, 64'(k) * 64'h3A5F, 64'hFFFF - 64'(k) * 64'h0123, k[0], k[1], 4'(k));
    for (int k = 4; k < 8; k++) begin
      check("b2b_valid", 0, 64'(out_valid_q[0]), 64'd1);
      check("b2b_tag", 0, 64'(tag_q[0]), 64'(k));
      tick();
    end
    check("b2b_done", 0, 64'(out_valid_q[0]), 64'd0);

    // Stall with a full pipe.
    for (int k = 0; k < 6; k++)
      issue(0, 64'h1000 * 64'(k + 1) + 64'h0F0F, 64'h0101 * 64'(k + 1), 1'b0, k[0], 4'(8 + k));
    out_ready_d[0] = 1'b0;
    a_d[0] = 64'h4444; b_d[0] = 64'h1111; cin_d[0] = 1'b0; sub_d[0] = 1'b1; tag_d[0] = 4'd14;
    in_valid_d[0] = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      check("stall_in_ready", 0, 64'(in_ready_q[0]), 64'd0);
      check("stall_valid", 0, 64'(out_valid_q[0]), 64'd1);
      check("stall_tag", 0, 64'(tag_q[0]), 64'd10);
      tick();
    end
    out_ready_d[0] = 1'b1;
    wait_accept(0);
    drain();

    // Reset with operations in flight.
    for (int k = 0; k < 5; k++)
      issue(0, 64'h1111 * 64'(k + 1), 64'h0101, 1'b1, 1'b0, 4'(k + 1));
    check("pre_reset_valid", 0, 64'(out_valid_q[0]), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst_valid", 0, 64'(out_valid_q[0]), 64'd0);
    check("rst_sum", 0, sum_q[0], 64'd0);
    check("rst_cout", 0, 64'(cout_q[0]), 64'd0);
    check("rst_ovf", 0, 64'(ovf_q[0]), 64'd0);
    check("rst_tag", 0, 64'(tag_q[0]), 64'd0);
    check("rst_in_ready", 0, 64'(in_ready_q[0]), 64'd1);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check("no_stale", 0, 64'(out_valid_q[0]), 64'd0);
      tick();
    end
    run_lit(64'h1234, 64'h4321, 1'b0, 1'b0, 64'h5555, 1'b0, 1'b0);
    drain();

    // Random regression on all instances.
    target = '{2000, 10000, 10000};
    acc_cnt = '{0, 0, 0};
    cyc = 0;
    while ((acc_cnt[0] < target[0] || acc_cnt[1] < target[1] || acc_cnt[2] < target[2]) && cyc < 60000) begin
      for (int i = 0; i < NI; i++) begin
        in_valid_d[i]  = (acc_cnt[i] < target[i]) && ($urandom_range(0, 9) < 8);
        a_d[i]         = rnd64();
        b_d[i]         = rnd64();
        cin_d[i]       = 1'($urandom_range(0, 1));
        sub_d[i]       = 1'($urandom_range(0, 1));
        tag_d[i]       = 4'($urandom_range(0, 15));
        out_ready_d[i] = ($urandom_range(0, 3) != 0);
      end
      #1;
      for (int i = 0; i < NI; i++)
        if (in_valid_d[i] && in_ready_q[i]) acc_cnt[i]++;
      tick();
      cyc++;
    end
    for (int i = 0; i < NI; i++) check("random_count", i, 64'(acc_cnt[i]), 64'(target[i]));
    in_valid_d = '0;
    out_ready_d = '1;
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/cla_pipe_adder.md
# cla_pipe_adder

Parametrised, pipelined carry-lookahead adder/subtractor for the wide additions in the Montgomery datapath. Operands are split into SEG-bit segments, and one segment is resolved per pipeline stage using 4-bit lookahead groups with group-level generate/propagate. The carry is registered between stages, and operand and result bits are skewed and de-skewed so each full-width result emerges aligned. Valid/ready handshakes on both sides give one result per cycle with backpressure.

## Interface
- WIDTH, 64: operand width; must be a multiple of SEG.
- SEG, 16: bits resolved per stage; must be a multiple of 4. NSTAGE = WIDTH/SEG.
- TAG_W, 4: width of the sideband tag carried alongside each operation.
- clk  input  1  clock.
- rst_n  input  1  reset. One clock; reset is asynchronous and active-low.
- in_valid  input  1  operation presented.
- in_ready  output  1  block accepts an operation this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add) or borrow-in (sub).
- op_sub  input  1  0 = A+B+cin; 1 = A−B−cin.
- tag_in  input  TAG_W  sideband, returned unchanged.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result modulo 2^WIDTH.
- cout  output  1  carry out of the MSB. For sub, 1 = no borrow.
- ovf  output  1  two's-complement signed overflow.
- tag_out  output  TAG_W  tag of the presented result.

## Operation
- Effective operands: B' = op_sub ? ~b : b. Carry-in c0 = cin ^ op_sub.
  - Sub with cin=1 therefore yields A−B−1, which supports multiword borrow chaining.
- Stage k (0..NSTAGE−1) computes bits [k·SEG +: SEG] of A + B' from the carry registered by stage k−1. Stage 0 uses c0.
- Within a segment, 4-bit groups produce G = A&B and P = A^B. Group carries come from lookahead equations; a ripple across groups is not allowed. Segment carry-out goes to the stage register.
- Upper operand segments are delayed k cycles before stage k. Lower result segments are delayed NSTAGE−1−k cycles so all of sum presents together.
- cout = carry out of the top segment.
- ovf = (A[MSB] == B'[MSB]) && (sum[MSB] != A[MSB]). It is evaluated in the last stage.
- Each stage register carries a valid bit. tag_in travels with stage-0 valid.
- Global stall: en = !(out_valid && !out_ready). All pipeline registers, including skew registers and valids, advance only when en=1.
- in_ready = en, a combinational function of out_valid and out_ready. An operation is accepted when in_valid && in_ready.
- Bubbles: when in_valid=0 with en=1, a zero valid enters stage 0 and data registers may hold any value.
- Outputs are registered (last stage). sum, cout, ovf and tag_out are meaningful only when out_valid=1 and hold stable while stalled.

## Timing
- Reset (rst_n low, asynchronous): all valid bits are 0, so out_valid=0. sum, cout, ovf, tag_out and all carry/skew registers are 0. in_ready=1 during and after reset.
- Reset mid-operation discards every in-flight operation. Nothing emerges after release until new accepts have travelled the pipe.
- Latency: an operation accepted at edge t has out_valid=1 after edge t+NSTAGE−1. With NSTAGE=1, the result is valid the cycle after accept.
- Throughput: 1 operation per cycle when out_ready is held 1.
- Stall: when out_valid=1 and out_ready=0, in_ready=0 the same cycle. Nothing is lost or duplicated, and the output holds.
- Simultaneous out_valid && out_ready && in_valid: the result is consumed and a new operation is accepted in the same edge.
- Operations exit strictly in acceptance order.
- Critical path per stage: one SEG-bit lookahead, with no dependence on other stages' combinational logic.

## Test plan
- WIDTH=16, SEG=4 (4 stages), add: a=0xFFFF, b=0x0001, cin=0 → after 4 edges sum=0x0000, cout=1, ovf=0. Full carry chain crosses all stage registers.
- Add a=0x7FFF, b=0x0001, cin=0 → sum=0x8000, cout=0, ovf=1. Sub a=0x0005, b=0x0007, cin=0 → sum=0xFFFE, cout=0, ovf=0. Sub same operands with cin=1 → sum=0xFFFD.
- Back-to-back accepts on 8 consecutive cycles with out_ready=1 and tags 0..7 → 8 consecutive out_valid cycles, tags 0..7 in order, each matching a reference model.
- out_ready=0 for 3 cycles while the pipe is full → in_ready=0 throughout, outputs frozen. On release the results resume in order with none dropped.
- Assert rst_n low for one cycle with 3 operations in flight → out_valid=0 immediately, all outputs 0, and no stale result after release.
- Random regression, WIDTH=64, SEG=16, and WIDTH=32, SEG=32, with random op_sub, cin and out_ready → sum, cout and ovf match a behavioural model for 10,000 operations.
